// File: rtl/mem_port_arbiter.sv
// Arbitrates one word-wide data memory between the fetch and load/store requesters.
// Byte and halfword stores are done as a read-modify-write; bad accesses get an error response.
module mem_port_arbiter #(
    parameter int WORDS        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_en,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    input  logic        ls_req_we,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    input  logic [1:0]  ls_req_size,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [29:0]      WORD_LIMIT = 30'(WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Insert right-justified store data into the old word at the addressed lane.
    function automatic logic [31:0] merge_sub(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
        logic [31:0] res;
        res = old_word;
        if (size == SZ_BYTE) begin
            case (lane)
                2'b00:   res[7:0]   = wdata[7:0];
                2'b01:   res[15:8]  = wdata[7:0];
                2'b10:   res[23:16] = wdata[7:0];
                2'b11:   res[31:24] = wdata[7:0];
                default: res        = old_word;
            endcase
        end else begin
            res = lane[1] ? {wdata[15:0], old_word[15:0]} : {old_word[31:16], wdata[15:0]};
        end
        return res;
    endfunction

    logic [0:0]       state_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [31:0]      rmw_addr_r;
    logic [31:0]      rmw_data_r;
    logic             if_rsp_valid_r;
    logic [31:0]      if_rsp_data_r;
    logic             if_rsp_err_r;
    logic             ls_rsp_valid_r;
    logic [31:0]      ls_rsp_data_r;
    logic             ls_rsp_err_r;

    logic fetch_prio_s;
    logic if_grant_s;
    logic ls_grant_s;
    logic if_err_s;
    logic ls_err_s;
    logic ls_word_wr_s;
    logic ls_rmw_s;

    assign fetch_prio_s = (starve_cnt_r >= STARVE_MAX);

    // Range, alignment and size checks for both requesters.
    always_comb begin
        if_err_s = (if_req_addr[31:2] >= WORD_LIMIT) || (if_req_addr[1:0] != 2'b00);
        ls_err_s = (ls_req_addr[31:2] >= WORD_LIMIT);
        case (ls_req_size)
            SZ_BYTE: ls_err_s = ls_err_s;
            SZ_HALF: ls_err_s = ls_err_s || ls_req_addr[0];
            SZ_WORD: ls_err_s = ls_err_s || (ls_req_addr[1:0] != 2'b00);
            default: ls_err_s = 1'b1;
        endcase
    end

    // Grant selection; load/store wins ties unless fetch has starved long enough.
    always_comb begin
        if_grant_s = 1'b0;
        ls_grant_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if_grant_s = if_req_valid && (!ls_req_valid || fetch_prio_s);
            ls_grant_s = ls_req_valid && !if_grant_s;
        end else begin
            if_grant_s = 1'b0;
            ls_grant_s = 1'b0;
        end
        ls_word_wr_s = ls_grant_s && ls_req_we && !ls_err_s && (ls_req_size == SZ_WORD);
        ls_rmw_s     = ls_grant_s && ls_req_we && !ls_err_s &&
                       ((ls_req_size == SZ_BYTE) || (ls_req_size == SZ_HALF));
    end

    assign if_req_ready = if_grant_s;
    assign ls_req_ready = ls_grant_s;

    // Memory port drive; a reset during the RMW write cycle suppresses the write.
    always_comb begin
        mem_address      = 32'h0000_0000;
        mem_write_data   = 32'h0000_0000;
        mem_write_enable = 1'b0;
        if (state_r == ST_RMW_WR) begin
            mem_address      = rmw_addr_r;
            mem_write_data   = rmw_data_r;
            mem_write_enable = !rst_en;
        end else if (ls_grant_s) begin
            mem_address = {ls_req_addr[31:2], 2'b00};
            if (ls_word_wr_s) begin
                mem_write_data   = ls_req_wdata;
                mem_write_enable = 1'b1;
            end else begin
                mem_write_data   = 32'h0000_0000;
                mem_write_enable = 1'b0;
            end
        end else if (if_grant_s) begin
            mem_address = {if_req_addr[31:2], 2'b00};
        end else begin
            mem_address = 32'h0000_0000;
        end
    end

    // State, starvation counter, RMW buffer and registered responses.
    always_ff @(posedge clk) begin
        if (rst_en) begin
            state_r        <= ST_IDLE;
            starve_cnt_r   <= '0;
            rmw_addr_r     <= 32'h0000_0000;
            rmw_data_r     <= 32'h0000_0000;
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= 32'h0000_0000;
            if_rsp_err_r   <= 1'b0;
            ls_rsp_valid_r <= 1'b0;
            ls_rsp_data_r  <= 32'h0000_0000;
            ls_rsp_err_r   <= 1'b0;
        end else begin
            if (if_grant_s) begin
                starve_cnt_r <= '0;
            end else if (if_req_valid && (starve_cnt_r != STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end

            if_rsp_valid_r <= if_grant_s;
            if (if_grant_s) begin
                if_rsp_err_r  <= if_err_s;
                if_rsp_data_r <= if_err_s ? 32'h0000_0000 : mem_read_data;
            end

            ls_rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ls_rmw_s) begin
                        state_r    <= ST_RMW_WR;
                        rmw_addr_r <= {ls_req_addr[31:2], 2'b00};
                        rmw_data_r <= merge_sub(mem_read_data, ls_req_wdata,
                                                ls_req_addr[1:0], ls_req_size);
                    end else if (ls_grant_s) begin
                        ls_rsp_valid_r <= 1'b1;
                        ls_rsp_err_r   <= ls_err_s;
                        ls_rsp_data_r  <= (ls_err_s || ls_req_we) ? 32'h0000_0000 : mem_read_data;
                    end
                end
                ST_RMW_WR: begin
                    state_r        <= ST_IDLE;
                    ls_rsp_valid_r <= 1'b1;
                    ls_rsp_err_r   <= 1'b0;
                    ls_rsp_data_r  <= 32'h0000_0000;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign if_rsp_valid = if_rsp_valid_r;
    assign if_rsp_data  = if_rsp_data_r;
    assign if_rsp_err   = if_rsp_err_r;
    assign ls_rsp_valid = ls_rsp_valid_r;
    assign ls_rsp_data  = ls_rsp_data_r;
    assign ls_rsp_err   = ls_rsp_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever a response pulse appears.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_en;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_we;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic [1:0]  ls_req_size;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    rsp_t        if_q [$];
    rsp_t        ls_q [$];
    rsp_t        if_e;
    rsp_t        ls_e;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.WORDS(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_en(rst_en),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_size(ls_req_size), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, posedge write.
    assign mem_read_data = (mem_address[31:8] == 24'h0) ? mem[mem_address[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (if_rsp_valid) begin
            if (if_q.size() == 0) begin
                chk("if_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                if_e = if_q.pop_front();
                chk("if_rsp_data", if_rsp_data, if_e.data);
                chk("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, if_e.err});
            end
        end
        if (ls_rsp_valid) begin
            if (ls_q.size() == 0) begin
                chk("ls_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                ls_e = ls_q.pop_front();
                chk("ls_rsp_data", ls_rsp_data, ls_e.data);
                chk("ls_rsp_err", {31'd0, ls_rsp_err}, {31'd0, ls_e.err});
            end
        end
    end

    task automatic drive_ls(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size);
        ls_req_valid = 1'b1;
        ls_req_we    = we;
        ls_req_addr  = addr;
        ls_req_wdata = wdata;
        ls_req_size  = size;
    endtask

    task automatic idle();
        @(negedge clk);
        ls_req_valid = 1'b0;
        if_req_valid = 1'b0;
    endtask

    // One load/store presented alone and accepted in the same cycle.
    task automatic ls_op(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic exp_we, input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        if_req_valid = 1'b0;
        drive_ls(we, addr, wdata, size);
        #1;
        chk({name, "_ready"}, {31'd0, ls_req_ready}, 32'd1);
        chk({name, "_mem_we"}, {31'd0, mem_write_enable}, {31'd0, exp_we});
        if (exp_we) chk({name, "_mem_wdata"}, mem_write_data, wdata);
        ls_q.push_back('{data: exp_data, err: exp_err});
    endtask

    initial begin
        rst_en = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 32'h0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = 32'h0;
        ls_req_wdata = 32'h0; ls_req_size = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
        chk("rst_ls_rsp_data", ls_rsp_data, 32'd0);
        chk("rst_if_rsp_err", {31'd0, if_rsp_err}, 32'd0);
        rst_en = 1'b0;

        // Preload words through the DUT.
        ls_op("pre0", 1'b1, 32'h00, 32'hCAFE_0000, 2'b10, 1'b1, 32'h0, 1'b0);
        ls_op("pre5", 1'b1, 32'h14, 32'h5566_7788, 2'b10, 1'b1, 32'h0, 1'b0);
        ls_op("pre8", 1'b1, 32'h20, 32'h8888_8888, 2'b10, 1'b1, 32'h0, 1'b0);
        ls_op("pre16", 1'b1, 32'h40, 32'h0000_A5A5, 2'b10, 1'b1, 32'h0, 1'b0);

        // Word store then load.
        ls_op("st_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h0, 1'b0);
        chk("st_word_addr", mem_address, 32'h10);
        ls_op("ld_word", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Byte store read-modify-write.
        ls_op("pre4", 1'b1, 32'h10, 32'h1122_3344, 2'b10, 1'b1, 32'h0, 1'b0);
        ls_op("st_byte", 1'b1, 32'h11, 32'h0000_00AA, 2'b00, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive_ls(1'b0, 32'h10, 32'h0, 2'b10);
        #1;
        chk("rmw_ls_ready", {31'd0, ls_req_ready}, 32'd0);
        chk("rmw_if_ready", {31'd0, if_req_ready}, 32'd0);
        chk("rmw_mem_we", {31'd0, mem_write_enable}, 32'd1);
        chk("rmw_mem_wdata", mem_write_data, 32'h1122_AA44);
        chk("rmw_mem_addr", mem_address, 32'h10);
        @(negedge clk);
        #1;
        chk("post_rmw_ls_ready", {31'd0, ls_req_ready}, 32'd1);
        ls_q.push_back('{data: 32'h1122_AA44, err: 1'b0});
        idle();

        // Starvation: ls wins four cycles, fetch the fifth, then ls again.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_req_valid = 1'b1;
            if_req_addr  = 32'h0;
            drive_ls(1'b0, 32'h20, 32'h0, 2'b10);
            #1;
            if (i == 4) begin
                chk("starve_if_ready", {31'd0, if_req_ready}, 32'd1);
                chk("starve_ls_ready", {31'd0, ls_req_ready}, 32'd0);
                if_q.push_back('{data: 32'hCAFE_0000, err: 1'b0});
            end else begin
                chk("starve_if_ready", {31'd0, if_req_ready}, 32'd0);
                chk("starve_ls_ready", {31'd0, ls_req_ready}, 32'd1);
                ls_q.push_back('{data: 32'h8888_8888, err: 1'b0});
            end
        end
        idle();

        // Error cases: no write, err response with zero data.
        ls_op("err_half", 1'b1, 32'h13, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0, 1'b1);
        ls_op("err_range", 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        ls_op("err_size", 1'b1, 32'h10, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h42;
        #1;
        chk("err_fetch_ready", {31'd0, if_req_ready}, 32'd1);
        if_q.push_back('{data: 32'h0, err: 1'b1});
        idle();
        chk("err_mem_unchanged", mem[4], 32'h1122_AA44);

        // Reset during RMW_WR with a saturated starvation counter.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if_req_valid = 1'b1;
            if_req_addr  = 32'h40;
            if (i < 3) begin
                drive_ls(1'b0, 32'h20, 32'h0, 2'b10);
                ls_q.push_back('{data: 32'h8888_8888, err: 1'b0});
            end else begin
                drive_ls(1'b1, 32'h14, 32'h0000_0011, 2'b00);
            end
            #1;
            chk("pre_rst_ls_ready", {31'd0, ls_req_ready}, 32'd1);
        end
        @(negedge clk);
        rst_en = 1'b1;
        ls_req_valid = 1'b0;
        if_req_valid = 1'b0;
        #1;
        chk("rst_rmw_mem_we", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clk);
        rst_en = 1'b0;
        chk("rst_rmw_no_rsp", {31'd0, ls_rsp_valid}, 32'd0);
        chk("rst_rmw_mem", mem[5], 32'h5566_7788);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        drive_ls(1'b0, 32'h14, 32'h0, 2'b10);
        #1;
        chk("rst_cnt_ls_ready", {31'd0, ls_req_ready}, 32'd1);
        chk("rst_cnt_if_ready", {31'd0, if_req_ready}, 32'd0);
        ls_q.push_back('{data: 32'h5566_7788, err: 1'b0});

        // Lone fetch accepted immediately.
        @(negedge clk);
        ls_req_valid = 1'b0;
        #1;
        chk("fetch_ready", {31'd0, if_req_ready}, 32'd1);
        chk("fetch_mem_addr", mem_address, 32'h40);
        if_q.push_back('{data: 32'h0000_A5A5, err: 1'b0});
        idle();

        repeat (3) @(negedge clk);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("ls_q_drained", ls_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported, word-addressed data memory between the instruction-fetch requester and the load/store requester.
- The memory has combinational read and posedge write.
- The block arbitrates with valid/ready handshakes and returns registered one-cycle responses.
- It sequences byte/halfword stores as a two-cycle read-modify-write, because the memory only writes whole words.
- It flags misaligned and out-of-range accesses instead of touching memory.

Parameters:
WORDS, 64, depth of the attached memory in 32-bit words; word index = address[31:2]
STARVE_LIMIT, 4, consecutive stalled fetch cycles after which fetch takes priority over load/store

Ports:
clk  input  1  clock
rst_en  input  1  synchronous, active-high reset
if_req_valid  input  1  fetch request valid
if_req_addr  input  32  fetch byte address
if_req_ready  output  1  fetch request accepted this cycle when valid
if_rsp_valid  output  1  fetch response pulse
if_rsp_data  output  32  fetched word
if_rsp_err  output  1  fetch misaligned/out-of-range
ls_req_valid  input  1  load/store request valid
ls_req_we  input  1  1 = store, 0 = load
ls_req_addr  input  32  load/store byte address
ls_req_wdata  input  32  store data, right-justified for byte/half
ls_req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
ls_req_ready  output  1  load/store request accepted this cycle when valid
ls_rsp_valid  output  1  load/store response pulse
ls_rsp_data  output  32  aligned word read (loads); 0 for stores
ls_rsp_err  output  1  misaligned/out-of-range/illegal size
mem_address  output  32  to memory address
mem_write_data  output  32  to memory write data
mem_write_enable  output  1  to memory write enable
mem_read_data  input  32  from memory (combinational read)

Behaviour:
- States: IDLE, RMW_WR. Reset forces IDLE.
- Reset values: all rsp outputs 0, starvation counter 0, rmw buffer 0. Reset during RMW_WR drops the pending write; no response is issued.
- Readiness: in IDLE, readiness is combinational from the valids, state and counter. In RMW_WR both readies are 0.
- Grant in IDLE:
  - ls wins when both are valid, unless starve_cnt >= STARVE_LIMIT; then fetch wins.
  - Only one ready is high per cycle. The grant holds only for the accept cycle.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, each cycle if_req_valid=1 and if_req_ready=0.
  - Clears on fetch accept.
  - Holds when if_req_valid=0.
- Memory outputs when idle: mem_address = {addr[31:2],2'b00} of the granted request, or 0 when idle. mem_write_enable = 0 except as stated below.
- Error checks, evaluated in the accept cycle:
  - Out-of-range: addr[31:2] >= WORDS.
  - Misaligned: word with addr[1:0]!=0; half with addr[0]=1; fetch with addr[1:0]!=0.
  - Illegal size: ls_req_size=11.
  - On error: no write, no RMW. The response comes next cycle with err=1 and data=0.
- Fetch / load: mem_read_data is registered in the accept cycle. rsp_valid=1 with the data the following cycle (latency 1).
- Word store: mem_write_enable=1 and mem_write_data=wdata in the accept cycle. ls_rsp_valid=1 next cycle.
- Byte/half store:
  - Accept cycle: merge mem_read_data with wdata[7:0] at byte lane addr[1:0], or wdata[15:0] at lane addr[1]. Latch the merged word and address; go to RMW_WR.
  - RMW_WR cycle: mem_write_enable=1 with the merged word; go to IDLE.
  - ls_rsp_valid next cycle (latency 2). A new request can be accepted in that same cycle.
- Responses are single-cycle pulses with no backpressure. rsp outputs other than valid hold their last value.

Test Plan:
- Reset, then ls word store addr 0x10 data 0xDEADBEEF, then load 0x10 -> write on accept cycle; load rsp 1 cycle later data 0xDEADBEEF, err 0.
- Byte store 0xAA to 0x11 over word 0x11223344 at 0x10 -> 2-cycle RMW, readies low in RMW_WR; subsequent load returns 0x1122AA44.
- Both valid every cycle, fetch 0x0 and loads from 0x20, with STARVE_LIMIT=4 -> ls granted 4 cycles, fetch granted on 5th, counter clears, ls resumes.
- Half store to 0x13, word load from 0x102 (WORDS=64), ls size 11 -> each err=1 next cycle, mem_write_enable never asserted, memory unchanged.
- rst_en asserted during RMW_WR -> no write, no ls_rsp_valid, state IDLE, counter 0.
- Fetch 0x40 with no ls request -> if_req_ready=1 same cycle, if_rsp_valid next cycle with word at index 16.
